// File: rtl/dcache_pkg.sv
// Shared types and field widths for the 2-way 16-set data cache controller.
package dcache_pkg;

   localparam int ADDR_W    = 32;
   localparam int WORD_W    = 32;
   localparam int LINE_W    = 256;
   localparam int IDX_W     = 4;
   localparam int TAG_W     = 23;
   localparam int OFF_W     = 5;
   localparam int TAGWORD_W = TAG_W + 2;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MISS,
      S_WRITEBACK,
      S_READMISS,
      S_READMISSOK
   } state_e;

endpackage

// File: rtl/dcache_word_mux.sv
// Word select and word merge over one cache line.
module dcache_word_mux
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [2:0]        word_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic [LINE_W-1:0] merged_o
);

   always_comb begin
      rdata_o  = line_i[word_i*WORD_W +: WORD_W];
      merged_o = line_i;
      merged_o[word_i*WORD_W +: WORD_W] = wdata_i;
   end

endmodule

// File: rtl/dcache_controller.sv
// Data cache controller: hit path, dirty write-back, refill and replay.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [WORD_W-1:0]    cpu_data_i,
   input  logic                 cpu_MemRead_i,
   input  logic                 cpu_MemWrite_i,
   output logic [WORD_W-1:0]    cpu_data_o,
   output logic                 cpu_stall_o,
   output logic [IDX_W-1:0]     sram_idx_o,
   output logic [TAGWORD_W-1:0] sram_tag_o,
   output logic [LINE_W-1:0]    sram_data_o,
   output logic                 sram_enable_o,
   output logic                 sram_write_o,
   input  logic [TAGWORD_W-1:0] sram_tag_i,
   input  logic [LINE_W-1:0]    sram_data_i,
   input  logic                 sram_hit_i,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_W-1:0]    mem_data_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   input  logic [LINE_W-1:0]    mem_data_i,
   input  logic                 mem_ack_i
);

   state_e                 state_q, state_d;
   logic [TAGWORD_W-1:0]   vtag_q, vtag_d;
   logic [LINE_W-1:0]      vdata_q, vdata_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [ADDR_W-1:0]      maddr_q, maddr_d;
   logic [LINE_W-1:0]      mdata_q, mdata_d;
   logic                   men_q, men_d;
   logic                   mwr_q, mwr_d;

   logic                   req;
   logic [ADDR_W-1:0]      cur_addr;
   logic [TAG_W-1:0]       cur_tag;
   logic [IDX_W-1:0]       cur_idx;
   logic [WORD_W-1:0]      rdata;
   logic [LINE_W-1:0]      merged;
   logic                   unused_lsb;

   assign req        = cpu_MemRead_i | cpu_MemWrite_i;
   assign cur_addr   = (state_q == S_IDLE) ? cpu_addr_i : addr_q;
   assign cur_tag    = cur_addr[ADDR_W-1 -: TAG_W];
   assign cur_idx    = cur_addr[OFF_W +: IDX_W];
   assign unused_lsb = ^cur_addr[1:0];

   assign sram_idx_o   = cur_idx;
   assign mem_addr_o   = maddr_q;
   assign mem_data_o   = mdata_q;
   assign mem_enable_o = men_q;
   assign mem_write_o  = mwr_q;
   assign cpu_stall_o  = req & ~((state_q == S_IDLE) & sram_hit_i);

   dcache_word_mux u_mux (
      .line_i   (sram_data_i),
      .word_i   (cur_addr[4:2]),
      .wdata_i  (cpu_data_i),
      .rdata_o  (rdata),
      .merged_o (merged)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         vtag_q  <= '0;
         vdata_q <= '0;
         addr_q  <= '0;
         maddr_q <= '0;
         mdata_q <= '0;
         men_q   <= 1'b0;
         mwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vtag_q  <= vtag_d;
         vdata_q <= vdata_d;
         addr_q  <= addr_d;
         maddr_q <= maddr_d;
         mdata_q <= mdata_d;
         men_q   <= men_d;
         mwr_q   <= mwr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      vtag_d        = vtag_q;
      vdata_d       = vdata_q;
      addr_d        = addr_q;
      maddr_d       = maddr_q;
      mdata_d       = mdata_q;
      men_d         = men_q;
      mwr_d         = mwr_q;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      sram_data_o   = '0;
      sram_tag_o    = {1'b1, 1'b0, cur_tag};
      cpu_data_o    = '0;
      unique case (state_q)
         S_IDLE: begin
            sram_enable_o = req;
            if (req && sram_hit_i) begin
               if (cpu_MemWrite_i) begin
                  sram_write_o = 1'b1;
                  sram_data_o  = merged;
                  sram_tag_o   = {1'b1, 1'b1, cur_tag};
               end else begin
                  cpu_data_o = rdata;
               end
            end else if (req) begin
               state_d = S_MISS;
               vtag_d  = sram_tag_i;
               vdata_d = sram_data_i;
               addr_d  = cpu_addr_i;
            end
         end
         S_MISS: begin
            men_d = 1'b1;
            if (vtag_q[VALID_BIT] && vtag_q[DIRTY_BIT]) begin
               state_d = S_WRITEBACK;
               mwr_d   = 1'b1;
               maddr_d = {vtag_q[TAG_W-1:0], cur_idx, {OFF_W{1'b0}}};
               mdata_d = vdata_q;
            end else begin
               state_d = S_READMISS;
               mwr_d   = 1'b0;
               maddr_d = {cur_tag, cur_idx, {OFF_W{1'b0}}};
            end
         end
         S_WRITEBACK: begin
            if (mem_ack_i) begin
               state_d = S_READMISS;
               mwr_d   = 1'b0;
               maddr_d = {cur_tag, cur_idx, {OFF_W{1'b0}}};
            end
         end
         S_READMISS: begin
            if (mem_ack_i) begin
               sram_enable_o = 1'b1;
               sram_write_o  = 1'b1;
               sram_data_o   = mem_data_i;
               men_d         = 1'b0;
               state_d       = S_READMISSOK;
            end
         end
         S_READMISSOK: state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with hand-computed expectations.
module tb_dcache_controller;
   import dcache_pkg::*;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic [ADDR_W-1:0]    cpu_addr_i;
   logic [WORD_W-1:0]    cpu_data_i;
   logic                 cpu_MemRead_i;
   logic                 cpu_MemWrite_i;
   logic [WORD_W-1:0]    cpu_data_o;
   logic                 cpu_stall_o;
   logic [IDX_W-1:0]     sram_idx_o;
   logic [TAGWORD_W-1:0] sram_tag_o;
   logic [LINE_W-1:0]    sram_data_o;
   logic                 sram_enable_o;
   logic                 sram_write_o;
   logic [TAGWORD_W-1:0] sram_tag_i;
   logic [LINE_W-1:0]    sram_data_i;
   logic                 sram_hit_i;
   logic [ADDR_W-1:0]    mem_addr_o;
   logic [LINE_W-1:0]    mem_data_o;
   logic                 mem_enable_o;
   logic                 mem_write_o;
   logic [LINE_W-1:0]    mem_data_i;
   logic                 mem_ack_i;

   int checks = 0;
   int failures = 0;
   int stalls;

   logic [LINE_W-1:0] line1, line2, line3, line4;

   always #5 clk_i = ~clk_i;

   dcache_controller dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_data_i     (cpu_data_i),
      .cpu_MemRead_i  (cpu_MemRead_i),
      .cpu_MemWrite_i (cpu_MemWrite_i),
      .cpu_data_o     (cpu_data_o),
      .cpu_stall_o    (cpu_stall_o),
      .sram_idx_o     (sram_idx_o),
      .sram_tag_o     (sram_tag_o),
      .sram_data_o    (sram_data_o),
      .sram_enable_o  (sram_enable_o),
      .sram_write_o   (sram_write_o),
      .sram_tag_i     (sram_tag_i),
      .sram_data_i    (sram_data_i),
      .sram_hit_i     (sram_hit_i),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_enable_o   (mem_enable_o),
      .mem_write_o    (mem_write_o),
      .mem_data_i     (mem_data_i),
      .mem_ack_i      (mem_ack_i)
   );

   task automatic chk(input string tag,
                      input logic [LINE_W-1:0] got,
                      input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      #1;
      if (cpu_stall_o) stalls++;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      line1 = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
               32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
      line2 = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
               32'h33333333, 32'h22222222, 32'h12345678, 32'hDEADBEEF};
      line3 = {32'h0, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0, 32'hBEEF0001, 32'hCAFEF00D};
      line4 = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
               32'h33333333, 32'hA5A5A5A5, 32'h11111111, 32'hDEADBEEF};
      rst_i = 1'b1;
      cpu_addr_i = '0;
      cpu_data_i = '0;
      cpu_MemRead_i = 1'b0;
      cpu_MemWrite_i = 1'b0;
      sram_tag_i = '0;
      sram_data_i = '0;
      sram_hit_i = 1'b0;
      mem_data_i = '0;
      mem_ack_i = 1'b0;
      stalls = 0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_men", mem_enable_o, 0);
      chk("rst_mwr", mem_write_o, 0);
      chk("rst_maddr", mem_addr_o, 0);
      chk("rst_mdata", mem_data_o, 0);
      chk("rst_stall", cpu_stall_o, 0);
      rst_i = 1'b0;

      // cold load 0x40
      cpu_addr_i = 32'h40;
      cpu_MemRead_i = 1'b1;
      #1;
      chk("cold_stall", cpu_stall_o, 1);
      chk("cold_sen", sram_enable_o, 1);
      chk("cold_idx", sram_idx_o, 2);
      chk("cold_swr", sram_write_o, 0);
      chk("cold_data", cpu_data_o, 0);
      tick();
      chk("miss_men", mem_enable_o, 0);
      chk("miss_sen", sram_enable_o, 0);
      tick();
      chk("rm_men", mem_enable_o, 1);
      chk("rm_mwr", mem_write_o, 0);
      chk("rm_addr", mem_addr_o, 32'h40);
      tick();
      chk("rm_hold", mem_enable_o, 1);
      mem_ack_i = 1'b1;
      mem_data_i = line1;
      #1;
      chk("fill_swr", sram_write_o, 1);
      chk("fill_sen", sram_enable_o, 1);
      chk("fill_tag", sram_tag_o, 25'h1000000);
      chk("fill_data", sram_data_o, line1);
      tick();
      mem_ack_i = 1'b0;
      #1;
      chk("rmok_men", mem_enable_o, 0);
      chk("rmok_stall", cpu_stall_o, 1);
      chk("rmok_swr", sram_write_o, 0);
      tick();
      sram_hit_i = 1'b1;
      sram_data_i = line1;
      sram_tag_i = 25'h1000000;
      #1;
      chk("hit_stall", cpu_stall_o, 0);
      chk("hit_data", cpu_data_o, 32'hDEADBEEF);
      chk("hit_swr", sram_write_o, 0);
      tick();

      // store hit 0x44
      cpu_MemRead_i = 1'b0;
      cpu_MemWrite_i = 1'b1;
      cpu_addr_i = 32'h44;
      cpu_data_i = 32'h12345678;
      #1;
      chk("st_stall", cpu_stall_o, 0);
      chk("st_swr", sram_write_o, 1);
      chk("st_data", sram_data_o, line2);
      chk("st_tag", sram_tag_o, 25'h1800000);
      chk("st_cpu", cpu_data_o, 0);
      tick();

      // dirty eviction load 0x1040, latency 2 per transfer
      cpu_MemWrite_i = 1'b0;
      cpu_MemRead_i = 1'b1;
      cpu_addr_i = 32'h1040;
      sram_hit_i = 1'b0;
      sram_tag_i = 25'h1800000;
      sram_data_i = line2;
      stalls = 0;
      tick();
      tick();
      chk("wb_men", mem_enable_o, 1);
      chk("wb_mwr", mem_write_o, 1);
      chk("wb_addr", mem_addr_o, 32'h40);
      chk("wb_data", mem_data_o, line2);
      tick();
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      #1;
      chk("wbrm_men", mem_enable_o, 1);
      chk("wbrm_mwr", mem_write_o, 0);
      chk("wbrm_addr", mem_addr_o, 32'h1040);
      tick();
      mem_ack_i = 1'b1;
      mem_data_i = line3;
      #1;
      chk("wbfill_swr", sram_write_o, 1);
      chk("wbfill_tag", sram_tag_o, 25'h1000008);
      tick();
      mem_ack_i = 1'b0;
      tick();
      sram_hit_i = 1'b1;
      sram_tag_i = 25'h1000008;
      sram_data_i = line3;
      #1;
      chk("wb_stalls", stalls, 7);
      chk("wbhit_stall", cpu_stall_o, 0);
      chk("wbhit_data", cpu_data_o, 32'hCAFEF00D);
      tick();

      // clean eviction load 0x2060
      cpu_addr_i = 32'h2060;
      sram_hit_i = 1'b0;
      sram_tag_i = 25'h1000005;
      sram_data_i = line1;
      tick();
      tick();
      chk("cl_men", mem_enable_o, 1);
      chk("cl_mwr", mem_write_o, 0);
      chk("cl_addr", mem_addr_o, 32'h2060);
      mem_ack_i = 1'b1;
      mem_data_i = line1;
      #1;
      chk("cl_tag", sram_tag_o, 25'h1000010);
      tick();
      mem_ack_i = 1'b0;
      tick();

      // reset during READMISS
      cpu_addr_i = 32'h80;
      sram_tag_i = '0;
      tick();
      tick();
      chk("rr_men", mem_enable_o, 1);
      rst_i = 1'b1;
      mem_ack_i = 1'b1;
      #1;
      chk("rr_men0", mem_enable_o, 0);
      chk("rr_swr", sram_write_o, 0);
      tick();
      rst_i = 1'b0;
      mem_ack_i = 1'b0;
      #1;
      chk("rr_remiss", cpu_stall_o, 1);
      tick();
      tick();
      chk("rr_men1", mem_enable_o, 1);
      chk("rr_addr", mem_addr_o, 32'h80);
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      tick();

      // read+write on a hit acts as store
      cpu_MemWrite_i = 1'b1;
      cpu_addr_i = 32'h48;
      cpu_data_i = 32'hA5A5A5A5;
      sram_hit_i = 1'b1;
      sram_data_i = line1;
      #1;
      chk("rw_stall", cpu_stall_o, 0);
      chk("rw_swr", sram_write_o, 1);
      chk("rw_data", sram_data_o, line4);
      chk("rw_cpu", cpu_data_o, 0);
      tick();

      // stray ack in IDLE
      cpu_MemRead_i = 1'b0;
      cpu_MemWrite_i = 1'b0;
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      tick();
      chk("ack_men", mem_enable_o, 0);
      cpu_MemRead_i = 1'b1;
      cpu_addr_i = 32'h44;
      #1;
      chk("ack_stall", cpu_stall_o, 0);
      chk("ack_data", cpu_data_o, 32'h11111111);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Initiator-side controller for the 2-way, 16-set, 256-bit-line data cache SRAM.
- Accepts 32-bit CPU load/store requests and drives the SRAM lookup/write port.
- On a miss it stalls the CPU, writes back a dirty victim line to data memory, refills the line, and then replays the access.
- Sits between the CPU MEM stage, the dcache SRAM and the 256-bit data memory.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, CPU data width.
- LINE_W, 256, cache line width (32 bytes).
- IDX_W, 4, set index width (16 sets).
- TAG_W, 23, address tag width; the SRAM tag word is TAG_W+2 bits: [24] valid, [23] dirty, [22:0] tag.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cpu_addr_i  in  32  byte address; tag=[31:9], idx=[8:5], word=[4:2]
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold the request
- sram_idx_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag} for compare or write
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  SRAM access
- sram_write_o  out  1  SRAM write; the SRAM picks the hit way, else the LRU way
- sram_tag_i  in  25  hit-way tag; on miss, the LRU victim tag
- sram_data_i  in  256  hit-way line; on miss, the victim line
- sram_hit_i  in  1  combinational hit (valid && tag[22:0] match; dirty ignored)
- mem_addr_o  out  32  line-aligned memory address
- mem_data_o  out  256  write-back line
- mem_enable_o  out  1  memory request, registered
- mem_write_o  out  1  write-back (1) or refill (0), registered
- mem_data_i  in  256  refill line, valid with ack
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Request: req = cpu_MemRead_i | cpu_MemWrite_i. If both are high, treat as a store.
- States: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
- Reset:
  - state=IDLE; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - Write-back address/data registers cleared.
  - Reset mid-miss aborts any memory transaction; the SRAM is not written.
- Combinational outputs:
  - sram_enable_o = req in IDLE; 1 on the refill write; 0 otherwise.
  - cpu_stall_o = req & ~(state==IDLE & sram_hit_i).
- IDLE, read hit:
  - Zero latency: cpu_data_o = sram_data_i word [word*32 +: 32].
  - No SRAM write.
- IDLE, write hit:
  - Same cycle: sram_write_o=1.
  - sram_data_o = sram_data_i with the selected word replaced by cpu_data_i.
  - sram_tag_o = {1,1,tag}; the update commits on the clock edge.
- IDLE, miss: go to MISS and latch the victim tag/data and cpu_addr_i.
- cpu_data_o = 0 whenever not returning hit data.
- MISS:
  - Victim valid & dirty: go to WRITEBACK.
  - mem_enable_o<=1, mem_write_o<=1, mem_addr_o<={victim tag, idx, 5'b0}, mem_data_o<=victim line.
  - Otherwise go to READMISS with mem_enable_o<=1, mem_write_o<=0, mem_addr_o<={tag, idx, 5'b0}.
- WRITEBACK:
  - Hold the outputs until mem_ack_i.
  - On ack, go to READMISS with mem_write_o<=0 and the refill address; mem_enable_o stays 1.
- READMISS:
  - Hold until mem_ack_i.
  - On the ack cycle: sram_enable_o=1, sram_write_o=1, sram_data_o=mem_data_i, sram_tag_o={1,0,tag}.
  - mem_enable_o<=0; go to READMISSOK.
- READMISSOK:
  - One bubble cycle, stall held; go to IDLE.
  - The replayed access then hits; a store sets dirty at that point.
- Request deasserted mid-miss: the miss still completes to IDLE.
- mem_ack_i outside WRITEBACK/READMISS is ignored.
- Memory latency is unbounded; there is no timeout.

Decomposition:
- Package dcache_pkg:
  - State enum (3-bit).
  - Field widths TAG_W/IDX_W/OFF_W=5.
  - Bit positions VALID_BIT=24 and DIRTY_BIT=23.
  - LINE_W, WORD_W.
- One combinational sub-module, dcache_word_mux: word select (read) and word merge (write) over a 256-bit line indexed by word[2:0].

Test Plan:
- Cold load of 0x0000_0040: stall rises; MISS→READMISS with mem_addr_o=0x40, mem_write_o=0; ack carrying a line whose word 0 is 0xDEADBEEF → SRAM written with tag {1,0,0}; READMISSOK→IDLE; hit returns 0xDEADBEEF and stall drops.
- Store 0x12345678 to 0x44 after that fill: zero-stall write hit; sram_data_o word 1 = 0x12345678, other words unchanged; sram_tag_o[23]=1.
- Dirty eviction, load 0x1040 with a dirty victim at tag 0, idx 2: WRITEBACK with mem_addr_o=0x40 and the victim line, then READMISS at 0x1040; total stall = memory latency ×2 + 3 cycles.
- Clean eviction: no WRITEBACK; the MISS→READMISS path only.
- rst_i asserted during READMISS: mem_enable_o=0 and state=IDLE immediately; no SRAM write; a post-reset load misses again.
- MemRead and MemWrite both high on a hit: performed as a store; mem_ack_i pulsed in IDLE: no state change.
